lanes_block_sync: RTL and testbench

Receive-path stage directly downstream of the two-lane deserializer. Samples the per-lane parallel words once per block period and checks the 64b/66b (Gen2) or 128b/132b (Gen3) sync headers. Runs a block-lock state machine, then strips headers and presents payload plus a control/data flag to the descrambler/decoder. Gen4 8-bit symbols pass through without header checks.

---
 rtl/lanes_block_sync.sv | 158 +++++++++++++++
 tb/tb_lanes_block_sync.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lanes_block_sync.sv
// Two-lane block sync: samples deserializer words once per block, checks Gen2/Gen3
// sync headers, runs block lock and presents payload. Optional SYNC_ERR_CNT_EN adds an error counter.
//
// state  | meaning
// HUNT   | searching for LOCK_CNT consecutive good blocks, no payload output
// LOCKED | payload forwarded; UNLOCK_CNT consecutive bad blocks return to HUNT
module lanes_block_sync #(
  parameter int WIDTH      = 132,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 8,
  parameter int STROBE_DLY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_dec,
  input  logic [1:0]       gen_speed,
  input  logic             descr_rst,
  input  logic [WIDTH-1:0] lane_0_rx_parallel,
  input  logic [WIDTH-1:0] lane_1_rx_parallel,
  output logic [127:0]     lane_0_data,
  output logic [127:0]     lane_1_data,
  output logic             lane_0_ctrl,
  output logic             lane_1_ctrl,
  output logic             data_valid,
  output logic             block_lock,
  output logic             sync_err,
  output logic [7:0]       sync_err_cnt
);

  localparam int IW = (WIDTH < 132) ? 132 : WIDTH;
  localparam logic [3:0] LOCK_M1   = 4'(LOCK_CNT - 1);
  localparam logic [3:0] UNLOCK_M1 = 4'(UNLOCK_CNT - 1);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  typedef struct packed {
    logic         valid;
    logic         ctrl;
    logic [127:0] pay;
  } lane_dec_t;

  function automatic lane_dec_t dec_lane(input logic [IW-1:0] w, input logic [1:0] gen);
    lane_dec_t d;
    d = '0;
    case (gen)
      2'b10: begin
        d.valid = (w[1:0] == 2'b01) || (w[1:0] == 2'b10);
        d.ctrl  = (w[1:0] == 2'b10);
        d.pay   = {64'd0, w[65:2]};
      end
      2'b01: begin
        d.valid = (w[3:0] == 4'b0011) || (w[3:0] == 4'b1100);
        d.ctrl  = (w[3:0] == 4'b1100);
        d.pay   = w[131:4];
      end
      default: begin
        d.valid = 1'b1;
        d.pay   = {120'd0, w[7:0]};
      end
    endcase
    return d;
  endfunction

  state_t                state;
  logic [STROBE_DLY-1:0] strb_sr;
  logic [3:0]            good_cnt;
  logic [3:0]            bad_cnt;
  logic [IW-1:0]         w0, w1;
  lane_dec_t             d0, d1;
  logic                  s_edge, gen4, blk_good, lock_after;

  assign w0       = IW'(lane_0_rx_parallel);
  assign w1       = IW'(lane_1_rx_parallel);
  assign d0       = dec_lane(w0, gen_speed);
  assign d1       = dec_lane(w1, gen_speed);
  assign s_edge   = strb_sr[STROBE_DLY-1];
  assign gen4     = ~(gen_speed[1] ^ gen_speed[0]);
  assign blk_good = d0.valid & d1.valid;

  // Lock status that results from the block sampled at this edge
  assign lock_after = gen4 ||
                      ((state == HUNT) ? (blk_good && (good_cnt == LOCK_M1))
                                       : (blk_good || (bad_cnt != UNLOCK_M1)));

  assign block_lock = (state == LOCKED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= HUNT;
      strb_sr     <= '0;
      good_cnt    <= '0;
      bad_cnt     <= '0;
      data_valid  <= 1'b0;
      sync_err    <= 1'b0;
      lane_0_data <= '0;
      lane_1_data <= '0;
      lane_0_ctrl <= 1'b0;
      lane_1_ctrl <= 1'b0;
    end else if (!enable_dec) begin
      state       <= HUNT;
      strb_sr     <= '0;
      good_cnt    <= '0;
      bad_cnt     <= '0;
      data_valid  <= 1'b0;
      sync_err    <= 1'b0;
      lane_0_data <= '0;
      lane_1_data <= '0;
      lane_0_ctrl <= 1'b0;
      lane_1_ctrl <= 1'b0;
    end else begin
      strb_sr[0] <= descr_rst;
      for (int i = 1; i < STROBE_DLY; i++) strb_sr[i] <= strb_sr[i-1];
      data_valid <= 1'b0;
      sync_err   <= 1'b0;
      if (s_edge) begin
        if (gen4) begin
          good_cnt <= '0;
          bad_cnt  <= '0;
        end else if (state == HUNT) begin
          bad_cnt  <= '0;
          good_cnt <= (blk_good && !lock_after) ? good_cnt + 4'd1 : 4'd0;
        end else begin
          good_cnt <= '0;
          bad_cnt  <= (!blk_good && lock_after) ? bad_cnt + 4'd1 : 4'd0;
        end
        state      <= lock_after ? LOCKED : HUNT;
        data_valid <= lock_after;
        sync_err   <= ~blk_good;
        // Payload held on the unlocking block and while hunting
        if (lock_after) begin
          lane_0_data <= d0.pay;
          lane_1_data <= d1.pay;
          lane_0_ctrl <= d0.ctrl;
          lane_1_ctrl <= d1.ctrl;
        end
      end
    end
  end

`ifdef SYNC_ERR_CNT_EN
  logic [7:0] err_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if (!enable_dec) begin
      err_cnt <= '0;
    end else if (s_edge && !blk_good && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign sync_err_cnt = err_cnt;
`else
  assign sync_err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_lanes_block_sync.sv
// Bench for lanes_block_sync: behavioural block-lock model compared every cycle,
// directed lock/unlock scenarios with literal expectations, then randomized blocks per generation.
module tb_lanes_block_sync;

  localparam int WIDTH      = 132;
  localparam int LOCK_CNT   = 4;
  localparam int UNLOCK_CNT = 8;
  localparam int STROBE_DLY = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable_dec;
  logic [1:0]       gen_speed;
  logic             descr_rst;
  logic [WIDTH-1:0] l0, l1;
  logic [127:0]     lane_0_data, lane_1_data;
  logic             lane_0_ctrl, lane_1_ctrl, data_valid, block_lock, sync_err;
  logic [7:0]       sync_err_cnt;

  int checks = 0;
  int errors = 0;

  lanes_block_sync #(
    .WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .STROBE_DLY(STROBE_DLY)
  ) dut (
    .clk(clk), .rst(rst), .enable_dec(enable_dec), .gen_speed(gen_speed),
    .descr_rst(descr_rst), .lane_0_rx_parallel(l0), .lane_1_rx_parallel(l1),
    .lane_0_data(lane_0_data), .lane_1_data(lane_1_data),
    .lane_0_ctrl(lane_0_ctrl), .lane_1_ctrl(lane_1_ctrl),
    .data_valid(data_valid), .block_lock(block_lock),
    .sync_err(sync_err), .sync_err_cnt(sync_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the block outputs must be, from the header/lock rules
  bit           sq[$];
  bit           s_now, m_locked, m_dv, m_err, m_c0, m_c1, v0, v1, c0, c1;
  int           m_good, m_bad, m_cnt;
  logic [127:0] m_d0, m_d1, p0, p1;

  function automatic void mdec(input logic [1:0] g, input logic [131:0] w,
                               output bit v, output bit c, output logic [127:0] p);
    int hdr;
    if (g == 2'b10) begin
      hdr = int'(w % 4);
      v = (hdr == 1) || (hdr == 2);
      c = (hdr == 2);
      p = 128'((w >> 2) & {68'd0, {64{1'b1}}});
    end else if (g == 2'b01) begin
      hdr = int'(w % 16);
      v = (hdr == 3) || (hdr == 12);
      c = (hdr == 12);
      p = 128'(w >> 4);
    end else begin
      v = 1'b1;
      c = 1'b0;
      p = 128'(w % 256);
    end
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst || !enable_dec) begin
      sq.delete();
      m_locked = 0; m_good = 0; m_bad = 0; m_cnt = 0;
      m_dv = 0; m_err = 0; m_c0 = 0; m_c1 = 0; m_d0 = '0; m_d1 = '0;
    end else begin
      s_now = 0;
      if (sq.size() == STROBE_DLY) begin
        s_now = sq[0];
        void'(sq.pop_front());
      end
      sq.push_back(descr_rst);
      m_dv = 0;
      m_err = 0;
      if (s_now) begin
        mdec(gen_speed, l0, v0, c0, p0);
        mdec(gen_speed, l1, v1, c1, p1);
        if (gen_speed == 2'b00 || gen_speed == 2'b11) begin
          m_locked = 1; m_good = 0; m_bad = 0;
        end else if (!m_locked) begin
          if (v0 && v1) begin
            m_good++; m_bad = 0;
            if (m_good == LOCK_CNT) begin m_locked = 1; m_good = 0; end
          end else m_good = 0;
        end else begin
          if (!(v0 && v1)) begin
            m_bad++;
            if (m_bad == UNLOCK_CNT) begin m_locked = 0; m_bad = 0; end
          end else m_bad = 0;
        end
        m_err = !(v0 && v1);
        if (m_err && m_cnt < 255) m_cnt++;
        if (m_locked) begin
          m_dv = 1; m_d0 = p0; m_d1 = p1; m_c0 = c0; m_c1 = c1;
        end
      end
    end
  end

  function automatic logic [7:0] exp_cnt(input int n);
`ifdef SYNC_ERR_CNT_EN
    return 8'(n);
`else
    return 8'h00;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("data_valid", data_valid, m_dv);
      chk("block_lock", block_lock, m_locked);
      chk("sync_err", sync_err, m_err);
      chk("sync_err_cnt", sync_err_cnt, exp_cnt(m_cnt));
      if (m_dv) begin
        chk("lane_0_data", lane_0_data, m_d0);
        chk("lane_1_data", lane_1_data, m_d1);
        chk("lane_0_ctrl", lane_0_ctrl, m_c0);
        chk("lane_1_ctrl", lane_1_ctrl, m_c1);
      end
    end
  end

  function automatic logic [131:0] g2w(input logic [1:0] h, input logic [63:0] p);
    return {66'd0, p, h};
  endfunction
  function automatic logic [131:0] g3w(input logic [3:0] h, input logic [127:0] p);
    return {p, h};
  endfunction
  function automatic logic [131:0] g4w(input logic [7:0] b);
    return {124'd0, b};
  endfunction

  function automatic logic [131:0] rnd_word(input logic [1:0] g);
    logic [159:0] r;
    logic [131:0] w;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    w = r[131:0];
    if (g == 2'b10 && $urandom_range(0, 7) != 0)
      w[1:0] = $urandom_range(0, 1) ? 2'b01 : 2'b10;
    else if (g == 2'b01 && $urandom_range(0, 7) != 0)
      w[3:0] = $urandom_range(0, 1) ? 4'b0011 : 4'b1100;
    return w;
  endfunction

  // Called at a negedge; returns at the negedge where this block's outputs are visible
  task automatic send_block(input logic [131:0] w0, input logic [131:0] w1);
    descr_rst = 1'b1;
    l0 = w0;
    l1 = w1;
    @(negedge clk);
    descr_rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic set_phase(input logic [1:0] g);
    @(negedge clk);
    enable_dec = 1'b0;
    gen_speed  = g;
    @(negedge clk);
    chk("clr_data_valid", data_valid, 0);
    chk("clr_block_lock", block_lock, 0);
    chk("clr_sync_err", sync_err, 0);
    chk("clr_sync_err_cnt", sync_err_cnt, 0);
    chk("clr_lane_0_data", lane_0_data, 0);
    enable_dec = 1'b1;
  endtask

  localparam logic [127:0] P3 = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
  localparam logic [127:0] Q3 = 128'hF0E1_D2C3_B4A5_9687_7869_5A4B_3C2D_1E0F;

  initial begin
    int errs;
    bit pat [8];
    logic [1:0] gens [4];
    rst = 1'b0; enable_dec = 1'b0; gen_speed = 2'b10; descr_rst = 1'b0; l0 = '0; l1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_block_lock", block_lock, 0);
    chk("rst_sync_err", sync_err, 0);
    chk("rst_sync_err_cnt", sync_err_cnt, 0);
    chk("rst_lane_1_data", lane_1_data, 0);
    rst = 1'b1;

    // Gen2: four good data blocks lock on the fourth
    set_phase(2'b10);
    for (int i = 0; i < 4; i++) begin
      send_block(g2w(2'b01, 64'h0123_4567_89AB_CDEF ^ 64'(i)), g2w(2'b01, 64'(i)));
      if (i < 3) chk("g2_no_early_lock", block_lock, 0);
    end
    chk("g2_lock", block_lock, 1);
    chk("g2_dv", data_valid, 1);
    chk("g2_l0_data", lane_0_data, 128'h0123_4567_89AB_CDEC);
    chk("g2_l0_ctrl", lane_0_ctrl, 0);

    // Gen3: ctrl on lane 1, data on lane 0
    set_phase(2'b01);
    repeat (4) send_block(g3w(4'b0011, P3), g3w(4'b1100, Q3));
    chk("g3_lock", block_lock, 1);
    chk("g3_l1_ctrl", lane_1_ctrl, 1);
    chk("g3_l0_ctrl", lane_0_ctrl, 0);
    chk("g3_l0_data", lane_0_data, P3);
    chk("g3_l1_data", lane_1_data, Q3);

    // Seven bad blocks stay inside the unlock window
    errs = 0;
    repeat (7) begin
      send_block(g3w(4'b0000, P3), g3w(4'b1100, Q3));
      errs += int'(sync_err);
    end
    chk("g3_err_pulses", errs, 7);
    chk("g3_lock_held", block_lock, 1);
    send_block(g3w(4'b0011, P3), g3w(4'b1100, Q3));
    chk("g3_good_after_bad", sync_err, 0);
    chk("g3_lock_after_good", block_lock, 1);

    // Eight bad blocks drop lock
    for (int i = 0; i < 8; i++) begin
      send_block(g3w(4'b0000, P3), g3w(4'b1100, Q3));
      if (i == 6) chk("g3_dv_in_window", data_valid, 1);
    end
    chk("g3_unlock", block_lock, 0);
    chk("g3_unlock_dv", data_valid, 0);
    send_block(g3w(4'b0000, P3), g3w(4'b1100, Q3));
    chk("g3_no_dv_after_unlock", data_valid, 0);
    chk("g3_err_after_unlock", sync_err, 1);

    // Gen2: a bad block restarts the good run
    set_phase(2'b10);
    pat = '{1, 1, 1, 0, 1, 1, 1, 1};
    for (int i = 0; i < 8; i++) begin
      send_block(g2w(pat[i] ? 2'b01 : 2'b11, 64'(i)), g2w(2'b10, 64'(i * 3)));
      if (i == 6) chk("g2_gggb_ggg_no_lock", block_lock, 0);
    end
    chk("g2_gggb_gggg_lock", block_lock, 1);
    chk("g2_l1_ctrl", lane_1_ctrl, 1);

    // Gen4: lock at the first sample edge
    set_phase(2'b00);
    send_block(g4w(8'hA5), g4w(8'h3C));
    chk("g4_lock", block_lock, 1);
    chk("g4_dv", data_valid, 1);
    chk("g4_l0_data", lane_0_data, 128'hA5);
    chk("g4_l1_data", lane_1_data, 128'h3C);

    // Async reset in the middle of a block period
    descr_rst = 1'b1;
    l0 = g4w(8'h11);
    @(negedge clk);
    descr_rst = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_lock", block_lock, 0);
    chk("arst_l0_data", lane_0_data, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_no_stale_dv", data_valid, 0);
    send_block(g4w(8'h5A), g4w(8'hC3));
    chk("arst_relock", block_lock, 1);
    chk("arst_l0_data_new", lane_0_data, 128'h5A);

    // Error counter saturation (enable drop inside set_phase clears it)
    set_phase(2'b10);
    repeat (300) send_block(g2w(2'b00, 64'h1), g2w(2'b11, 64'h2));
`ifdef SYNC_ERR_CNT_EN
    chk("sat_cnt", sync_err_cnt, 8'hFF);
`else
    chk("sat_cnt", sync_err_cnt, 8'h00);
`endif
    chk("sat_no_lock", block_lock, 0);

    // Randomized blocks per generation, checked by the model
    gens = '{2'b10, 2'b01, 2'b00, 2'b11};
    for (int g = 0; g < 4; g++) begin
      set_phase(gens[g]);
      repeat (60) send_block(rnd_word(gens[g]), rnd_word(gens[g]));
    end

    // Enable drop while locked
    set_phase(2'b00);
    send_block(g4w(8'h77), g4w(8'h88));
    chk("final_lock", block_lock, 1);
    set_phase(2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
